// File: rtl/hex_disp_ctrl.sv
// Multi-digit 7-segment controller: per-digit/word loads, sequential binary-to-BCD
// conversion with saturation, per-digit blank and blink, registered segment outputs.
module hex_disp_ctrl #(
  parameter int unsigned Digits    = 4,
  parameter bit          ActiveLow = 1'b1,
  parameter int unsigned BlinkBits = 26,
  localparam int unsigned DigW     = (Digits > 1) ? $clog2(Digits) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DigW-1:0]       wr_dig_i,
  input  logic [3:0]            wr_val_i,
  input  logic                  ld_en_i,
  input  logic                  ld_dec_i,
  input  logic [4*Digits-1:0]   ld_data_i,
  input  logic [Digits-1:0]     blank_mask_i,
  input  logic [Digits-1:0]     blink_mask_i,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic [7*Digits-1:0]   seg_o
);

  localparam int unsigned DataW = 4 * Digits;
  localparam int unsigned BcdW  = DataW + 4;
  localparam int unsigned ShW   = BcdW + DataW;
  localparam int unsigned StepW = $clog2(DataW + 1);

  localparam logic [StepW-1:0]    LastStep = StepW'(DataW - 1);
  localparam logic [DataW-1:0]    DecLimit = DataW'(10 ** Digits);
  localparam logic [7*Digits-1:0] SegOff   = ActiveLow ? {7*Digits{1'b1}} : '0;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e                      state_q, state_d;
  logic [ShW-1:0]              sh_q, sh_d, sh_adj, sh_step;
  logic [StepW-1:0]            step_q, step_d;
  logic                        ovf_next_q, ovf_next_d;
  logic                        ovf_q, ovf_d;
  logic [Digits-1:0][3:0]      digit_q, digit_d;
  logic [BlinkBits-1:0]        blink_q;
  logic [7*Digits-1:0]         seg_q, seg_d;

  // Active-high glyph {g,f,e,d,c,b,a}; b and d are lowercase.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Double-dabble step: correct every BCD nibble >= 5, then shift the whole register left.
  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < int'(Digits) + 1; i++) begin
      if (sh_q[DataW + 4*i +: 4] >= 4'd5) begin
        sh_adj[DataW + 4*i +: 4] = sh_q[DataW + 4*i +: 4] + 4'd3;
      end
    end
  end

  assign sh_step = {sh_adj[ShW-2:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    step_d     = step_q;
    ovf_next_d = ovf_next_q;
    ovf_d      = ovf_q;
    digit_d    = digit_q;
    case (state_q)
      StIdle: begin
        if (ld_en_i) begin
          if (ld_dec_i) begin
            state_d    = StConv;
            sh_d       = {{BcdW{1'b0}}, ld_data_i};
            step_d     = '0;
            ovf_next_d = (ld_data_i >= DecLimit);
          end else begin
            digit_d = ld_data_i;
          end
        end else if (wr_en_i && (32'(wr_dig_i) < Digits)) begin
          digit_d[wr_dig_i] = wr_val_i;
        end
      end
      StConv: begin
        sh_d   = sh_step;
        step_d = step_q + 1'b1;
        if (step_q == LastStep) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        digit_d = ovf_next_q ? {Digits{4'd9}} : sh_q[DataW +: DataW];
        ovf_d   = ovf_next_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < int'(Digits); i++) begin
      logic [6:0] g;
      g = (blank_mask_i[i] || (blink_mask_i[i] && blink_q[BlinkBits-1])) ? 7'h00
                                                                          : hex_glyph(digit_q[i]);
      seg_d[7*i +: 7] = ActiveLow ? ~g : g;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      step_q     <= '0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
      digit_q    <= '0;
      blink_q    <= '0;
      seg_q      <= SegOff;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      step_q     <= step_d;
      ovf_next_q <= ovf_next_d;
      ovf_q      <= ovf_d;
      digit_q    <= digit_d;
      blink_q    <= blink_q + 1'b1;
      seg_q      <= seg_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign ovf_o  = ovf_q;
  assign seg_o  = seg_q;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Bench for hex_disp_ctrl (4 digits, active-low, 4-bit blink counter): directed steps
// followed by random operations checked against a decimal/array reference model.
module tb_hex_disp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_dig;
  logic [3:0]  wr_val;
  logic        ld_en;
  logic        ld_dec;
  logic [15:0] ld_data;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        busy;
  logic        ovf;
  logic [27:0] seg;

  int checks   = 0;
  int failures = 0;

  int mdig[4];
  bit movf;
  int edges = 0;

  // Active-low glyphs for 0..F.
  logic [6:0] glyph_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_disp_ctrl #(
    .Digits   (4),
    .ActiveLow(1'b1),
    .BlinkBits(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_dig_i    (wr_dig),
    .wr_val_i    (wr_val),
    .ld_en_i     (ld_en),
    .ld_dec_i    (ld_dec),
    .ld_data_i   (ld_data),
    .blank_mask_i(blank_mask),
    .blink_mask_i(blink_mask),
    .busy_o      (busy),
    .ovf_o       (ovf),
    .seg_o       (seg)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the glyph on seg uses the blink phase of the previous edge.
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] exp_seg();
    logic [27:0] s;
    bit phase;
    phase = (edges > 0) && (((edges - 1) % 16) >= 8);
    for (int i = 0; i < 4; i++) begin
      s[7*i +: 7] = (blank_mask[i] || (blink_mask[i] && phase)) ? 7'h7F : glyph_al[mdig[i]];
    end
    return s;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'(exp_seg()));
    chk({tag, "_ovf"}, 32'(ovf), 32'(movf));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_write(input int d, input int v);
    wr_en  = 1'b1;
    wr_dig = 2'(d);
    wr_val = 4'(v);
    step(1);
    wr_en  = 1'b0;
    mdig[d] = v;
  endtask

  task automatic raw_load(input logic [15:0] v);
    ld_en   = 1'b1;
    ld_dec  = 1'b0;
    ld_data = v;
    step(1);
    ld_en   = 1'b0;
    for (int i = 0; i < 4; i++) mdig[i] = int'(v[4*i +: 4]);
  endtask

  // Decimal load; optionally pokes wr_en/ld_en mid-conversion, which must be ignored.
  task automatic dec_load(input string tag, input int v, input bit poke);
    int n;
    ld_en   = 1'b1;
    ld_dec  = 1'b1;
    ld_data = 16'(v);
    step(1);
    ld_en   = 1'b0;
    ld_dec  = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (poke && n == 5) begin
        wr_en = 1'b1; wr_dig = 2'd0; wr_val = 4'hF;
        ld_en = 1'b1; ld_data = 16'h1111;
      end else begin
        wr_en = 1'b0; ld_en = 1'b0;
      end
      step(1);
      n++;
    end
    wr_en = 1'b0;
    ld_en = 1'b0;
    chk({tag, "_busy_len"}, 32'(n), 32'd17);
    if (v >= 10000) begin
      for (int i = 0; i < 4; i++) mdig[i] = 9;
      movf = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) mdig[i] = (v / (10 ** i)) % 10;
      movf = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_dig = '0; wr_val = '0; ld_en = 1'b0; ld_dec = 1'b0;
    ld_data = '0; blank_mask = '0; blink_mask = '0;
    for (int i = 0; i < 4; i++) mdig[i] = 0;
    movf = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    do_write(1, 7);
    step(1);

    // Reset mid-sequence, held for 3 edges.
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdig[i] = 0;
    movf = 1'b0;
    chk("rst_seg", 32'(seg), 32'h0FFF_FFFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    step(1);
    chk_state("after_rst");

    // Single digit write shows after two edges.
    do_write(2, 10);
    step(1);
    chk("wr_hex2_A", 32'(seg[20:14]), 32'h08);
    chk_state("wr_A");

    dec_load("dec1234", 1234, 1'b0);
    step(1);
    chk_state("dec1234");

    dec_load("dec12345", 12345, 1'b0);
    step(1);
    chk_state("dec12345");

    raw_load(16'hBEEF);
    step(1);
    chk_state("raw_beef");

    // ld_en beats wr_en in the same cycle.
    wr_en = 1'b1; wr_dig = 2'd1; wr_val = 4'hC;
    raw_load(16'h5555);
    wr_en = 1'b0;
    step(1);
    chk_state("ld_beats_wr");

    dec_load("dec42_poke", 42, 1'b1);
    step(1);
    chk_state("busy_ignore");

    // Blink on hex0 over two full periods.
    blink_mask = 4'b0001;
    step(1);
    for (int k = 0; k < 32; k++) begin
      chk("blink", 32'(seg), 32'(exp_seg()));
      step(1);
    end
    blink_mask = 4'b0000;
    blank_mask = 4'b1000;
    step(1);
    for (int k = 0; k < 6; k++) begin
      chk("blank_hex3", 32'(seg[27:21]), 32'h7F);
      step(1);
    end
    blank_mask = 4'b0000;
    step(1);
    chk_state("unmasked");

    // Reset during conversion aborts it.
    ld_en = 1'b1; ld_dec = 1'b1; ld_data = 16'd9876;
    step(1);
    ld_en = 1'b0; ld_dec = 1'b0;
    step(5);
    chk("conv_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) mdig[i] = 0;
    movf = 1'b0;
    step(1);
    chk_state("abort");

    // Random operations against the model.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        1: raw_load(16'($urandom));
        2: dec_load("rnd_dec", ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 9999))
                                                          : int'($urandom_range(0, 65535)),
                    1'b0);
        default: begin
          blank_mask = 4'($urandom);
          blink_mask = 4'($urandom);
        end
      endcase
      step(1);
      chk_state("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
